backing_mem: RTL and testbench
==============================

Name: backing_mem

Overview:
- Main-memory model on the cache controller's miss path.
- Consumes the controller's fill request (mem_rd_en, mem_addr) and returns a line as a burst of 64-bit beats (mem_data, mem_data_valid) after a fixed latency.
- Bench preloads contents through a backdoor write port.
- Sits directly downstream of the cache controller; used by block- and top-level benches.

Parameters:
DEPTH, 1024, number of 64-bit words; power of 2; IDX_W = $clog2(DEPTH)
LATENCY, 4, cycles from request-accept edge to first beat; >= 1
BURST_LEN, 4, beats per request; power of 2, <= DEPTH; BW = $clog2(BURST_LEN)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
mem_rd_en  input  1  fill request level from cache controller
mem_addr  input  32  byte address of requested word
mem_data  output  64  beat data
mem_data_valid  output  1  beat valid, one per beat
bd_wr_en  input  1  backdoor write strobe
bd_idx  input  IDX_W  backdoor word index
bd_data  input  64  backdoor write data
proto_err  output  1  sticky protocol error (present only with BACKING_MEM_PROTO_CHK_EN)

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous, active-high.
- Reset: state IDLE, mem_data = 0, mem_data_valid = 0, rd_en_q = 0, counters = 0, proto_err = 0.
  - Storage array is not cleared by reset.
  - Reset mid-WAIT or mid-BURST aborts the request; no further beats.
- Initial contents (time zero): word i = {i[31:0], ~i[31:0]}.
- Request detection is edge-based:
  - req = mem_rd_en & ~rd_en_q; rd_en_q registers mem_rd_en every cycle.
  - A level held high produces exactly one request.
- Address mapping:
  - base = mem_addr[IDX_W+2:3].
  - mem_addr[2:0] is ignored; bits above IDX_W+2 are ignored (aliasing).
  - base is latched at accept.
- Beat k (k = 0..BURST_LEN-1) reads index {base[IDX_W-1:BW], base[BW-1:0]+k mod BURST_LEN}. This is a wrapping, critical-word-first burst.
- States:
  - IDLE: req -> latch base.
    - If LATENCY==1, go to BURST.
    - Otherwise go to WAIT with lat_cnt = LATENCY-1.
  - WAIT: lat_cnt decrements each cycle; when lat_cnt reaches 1, next state is BURST.
  - BURST: mem_data_valid = 1 for BURST_LEN consecutive cycles; beat_cnt increments; after the last beat go to IDLE.
- Timing: mem_rd_en rises in cycle N (sampled at the edge ending cycle N) -> beats valid in cycles N+LATENCY .. N+LATENCY+BURST_LEN-1.
- Data path:
  - mem_data and mem_data_valid are registered.
  - mem_data is loaded from the array at the edge that starts each beat cycle.
  - Outside beats, mem_data holds the last beat value and mem_data_valid = 0.
- A req seen in WAIT or BURST (new rising edge while busy) is dropped.
- A req is accepted in the first cycle after the last beat (IDLE).
- Backdoor write: mem[bd_idx] <= bd_data at the clock edge, in any state.
  - A write to the same word on the edge that loads a beat returns the OLD data for that beat.
  - Later beats see the new data.
- Backdoor writes are not blocked by rst (array is non-reset storage).

Optional Feature:
- Macro: BACKING_MEM_PROTO_CHK_EN.
- Defined:
  - proto_err port exists.
  - proto_err is set to 1 at the edge after any req seen in WAIT/BURST, or after mem_rd_en deasserts while in WAIT or BURST (controller dropped the request early).
  - proto_err is sticky until rst.
  - A $error is printed with the cycle's mem_addr.
  - Servicing is unaffected.
- Undefined: no proto_err port, no checks; dropped-request behaviour is identical.

Test Plan:
1. Defaults, mem_rd_en 0->1 in cycle 0, mem_addr=0x20, held high -> valid in cycles 4..7 with data {32'h4,32'hFFFFFFFB}, {32'h5,..FA}, {32'h6,..F9}, {32'h7,..F8}; valid low in cycle 8.
2. mem_addr=0x3C (word 7, low bits nonzero) -> beats return words 7,4,5,6 (wrap within aligned 4-word block).
3. Backdoor write bd_idx=9, bd_data=64'h1234_5678_9ABC_DEF0, then request mem_addr=0x48 -> first beat 64'h1234_5678_9ABC_DEF0, then words 10,11,8 initial pattern.
4. mem_rd_en held high for 20 cycles -> exactly one 4-beat burst; then drop for 1 cycle and re-raise -> second burst starting 4 cycles after the re-raise.
5. rst asserted asynchronously in cycle 2 of WAIT -> mem_data = 0 and valid = 0 immediately; no beats follow; a new request after reset release returns correct data on schedule.
6. Second rising edge of mem_rd_en during BURST -> ignored, no extra beats. With BACKING_MEM_PROTO_CHK_EN, proto_err = 1 from the next cycle until rst.

Source files
------------

// File: rtl/backing_mem.sv
// backing_mem: main-memory model returning fixed-latency, critical-word-first wrapping bursts.
// Define BACKING_MEM_PROTO_CHK_EN to add the sticky proto_err checker.
module backing_mem #(
  parameter int DEPTH = 1024,
  parameter int LATENCY = 4,
  parameter int BURST_LEN = 4,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int BW = $clog2(BURST_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_rd_en,
  input  logic [31:0]      mem_addr,
  output logic [63:0]      mem_data,
  output logic             mem_data_valid,
  input  logic             bd_wr_en,
  input  logic [IDX_W-1:0] bd_idx,
  input  logic [63:0]      bd_data
`ifdef BACKING_MEM_PROTO_CHK_EN
  ,
  output logic             proto_err
`endif
);
  localparam int CW = BW > 0 ? BW : 1;
  localparam int LW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  localparam logic [IDX_W-1:0] MASK = IDX_W'(BURST_LEN - 1);
  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;
  state_t state;
  logic rd_en_q, req, unused_addr;
  logic [IDX_W-1:0] base, addr_idx, nxt_idx, rd_idx;
  logic [CW-1:0] beat_cnt;
  logic [LW-1:0] lat_cnt;
  logic [63:0] ram [DEPTH];
  logic [63:0] rd_word;
  // Words never written through the backdoor read back as the power-up pattern {i, ~i}.
  logic [DEPTH-1:0] ovr = '0;
  always_comb begin
    req = mem_rd_en & ~rd_en_q;
    addr_idx = mem_addr[IDX_W+2:3];
    nxt_idx = (base & ~MASK) | ((base + IDX_W'(beat_cnt) + IDX_W'(1)) & MASK);
    rd_idx = state == IDLE ? addr_idx : state == WAIT ? base : nxt_idx;
    rd_word = ovr[rd_idx] ? ram[rd_idx] : {32'(rd_idx), ~32'(rd_idx)};
    unused_addr = ^{mem_addr[31:IDX_W+3], mem_addr[2:0]};
  end
  always_ff @(posedge clk) begin
    if (bd_wr_en) begin
      ram[bd_idx] <= bd_data;
      ovr[bd_idx] <= 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rd_en_q <= 1'b0;
      base <= '0;
      beat_cnt <= '0;
      lat_cnt <= '0;
      mem_data <= '0;
      mem_data_valid <= 1'b0;
`ifdef BACKING_MEM_PROTO_CHK_EN
      proto_err <= 1'b0;
`endif
    end else begin
      rd_en_q <= mem_rd_en;
      case (state)
        IDLE: if (req) begin
          base <= addr_idx;
          beat_cnt <= '0;
          lat_cnt <= LW'(LATENCY - 1);
          state <= LATENCY == 1 ? BURST : WAIT;
          if (LATENCY == 1) begin
            mem_data <= rd_word;
            mem_data_valid <= 1'b1;
          end
        end
        WAIT: begin
          lat_cnt <= lat_cnt - LW'(1);
          if (lat_cnt == LW'(1)) begin
            state <= BURST;
            mem_data <= rd_word;
            mem_data_valid <= 1'b1;
          end
        end
        BURST: begin
          beat_cnt <= beat_cnt + CW'(1);
          if (beat_cnt == CW'(BURST_LEN - 1)) begin
            state <= IDLE;
            mem_data_valid <= 1'b0;
          end else mem_data <= rd_word;
        end
        default: state <= IDLE;
      endcase
`ifdef BACKING_MEM_PROTO_CHK_EN
      if (state != IDLE && (req || !mem_rd_en)) begin
        proto_err <= 1'b1;
        $error("backing_mem: request protocol violation while busy, mem_addr=%h", mem_addr);
      end
`endif
    end
  end
endmodule

// File: tb/tb_backing_mem.sv
// tb_backing_mem: directed checks of burst timing, wrap order, backdoor writes,
// async reset abort and dropped requests on backing_mem.
module tb_backing_mem;
  logic clk = 1'b0, rst = 1'b1, mem_rd_en = 1'b0, bd_wr_en = 1'b0, mem_data_valid;
  logic [31:0] mem_addr = '0;
  logic [63:0] mem_data, bd_data = '0;
  logic [9:0] bd_idx = '0;
`ifdef BACKING_MEM_PROTO_CHK_EN
  logic proto_err;
`endif
  int n_tests = 0, n_fail = 0;
  backing_mem dut (
    .clk(clk),
    .rst(rst),
    .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .mem_data_valid(mem_data_valid),
    .bd_wr_en(bd_wr_en),
    .bd_idx(bd_idx),
    .bd_data(bd_data)
`ifdef BACKING_MEM_PROTO_CHK_EN
    ,
    .proto_err(proto_err)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // Raise mem_rd_en in cycle 0 and check valid/data for ncyc cycles; beats expected in cycles 4..7.
  task automatic run(input string tag, input logic [31:0] a, input int ncyc, input int drop,
                     input int rerise, input logic [63:0] e [4]);
    for (int c = 0; c < ncyc; c++) begin
      tick();
      if (c == 0) begin
        mem_rd_en = 1'b1;
        mem_addr = a;
      end
      if (c == drop) mem_rd_en = 1'b0;
      if (c == rerise) mem_rd_en = 1'b1;
      @(negedge clk);
      chk($sformatf("%s c%0d valid", tag, c), 64'(mem_data_valid), 64'(c >= 4 && c <= 7));
      if (c >= 4 && c <= 7) chk($sformatf("%s c%0d data", tag, c), mem_data, e[c-4]);
    end
    mem_rd_en = 1'b0;
  endtask
  initial begin
    #2;
    chk("reset data", mem_data, 64'h0);
    chk("reset valid", 64'(mem_data_valid), 64'h0);
    tick();
    tick();
    rst = 1'b0;
    run("t1 aligned", 32'h20, 9, -1, -1,
        '{64'h00000004_FFFFFFFB, 64'h00000005_FFFFFFFA, 64'h00000006_FFFFFFF9, 64'h00000007_FFFFFFF8});
    run("t2 wrap", 32'h3C, 9, -1, -1,
        '{64'h00000007_FFFFFFF8, 64'h00000004_FFFFFFFB, 64'h00000005_FFFFFFFA, 64'h00000006_FFFFFFF9});
    tick();
    bd_wr_en = 1'b1;
    bd_idx = 10'd9;
    bd_data = 64'h1234_5678_9ABC_DEF0;
    tick();
    bd_wr_en = 1'b0;
    run("t3 backdoor", 32'h48, 9, -1, -1,
        '{64'h1234_5678_9ABC_DEF0, 64'h0000000A_FFFFFFF5, 64'h0000000B_FFFFFFF4, 64'h00000008_FFFFFFF7});
    run("t4 hold", 32'h0, 20, -1, -1,
        '{64'h00000000_FFFFFFFF, 64'h00000001_FFFFFFFE, 64'h00000002_FFFFFFFD, 64'h00000003_FFFFFFFC});
    run("t4 rerise", 32'h0, 9, -1, -1,
        '{64'h00000000_FFFFFFFF, 64'h00000001_FFFFFFFE, 64'h00000002_FFFFFFFD, 64'h00000003_FFFFFFFC});
    tick();
    mem_rd_en = 1'b1;
    mem_addr = 32'h20;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    chk("t5 async rst data", mem_data, 64'h0);
    chk("t5 async rst valid", 64'(mem_data_valid), 64'h0);
    mem_rd_en = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      @(negedge clk);
      chk($sformatf("t5 aborted c%0d valid", c), 64'(mem_data_valid), 64'h0);
    end
    run("t5 after rst", 32'h3C, 9, -1, -1,
        '{64'h00000007_FFFFFFF8, 64'h00000004_FFFFFFFB, 64'h00000005_FFFFFFFA, 64'h00000006_FFFFFFF9});
`ifdef BACKING_MEM_PROTO_CHK_EN
    chk("proto_err clean", 64'(proto_err), 64'h0);
`endif
    run("t6 busy edge", 32'h60, 13, 4, 5,
        '{64'h0000000C_FFFFFFF3, 64'h0000000D_FFFFFFF2, 64'h0000000E_FFFFFFF1, 64'h0000000F_FFFFFFF0});
`ifdef BACKING_MEM_PROTO_CHK_EN
    chk("proto_err sticky", 64'(proto_err), 64'h1);
    rst = 1'b1;
    #1;
    chk("proto_err cleared", 64'(proto_err), 64'h0);
    rst = 1'b0;
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
